barrel_shift_right_pipe: RTL and testbench

BARREL_SHIFT_RIGHT_PIPE -- requirements
Module: barrel_shift_right_pipe

---
 rtl/barrel_shift_right_pipe_if.sv | 40 ++++
 rtl/barrel_shift_right_pipe.sv | 71 +++++++
 tb/tb_barrel_shift_right_pipe.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shift_right_pipe_if.sv
// Valid/ready stream bundle for the pipelined right barrel shifter.
// Operand side carries data, shift amount and mode; result side data and sticky.
interface barrel_shift_right_pipe_if #(
    parameter int WIDTH = 16,
    parameter int SW    = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_shamt;
    logic             in_arith;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sticky;

    modport master (
        output in_valid,
        output in_data,
        output in_shamt,
        output in_arith,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sticky
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_shamt,
        input  in_arith,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sticky
    );
endinterface

// File: rtl/barrel_shift_right_pipe.sv
// Right barrel shifter, one registered stage per shift-amount bit.
// Logical/arithmetic fill, sticky OR of discarded bits, valid/ready flow.
module barrel_shift_right_pipe #(
    parameter int WIDTH = 16
) (
    input logic                      clk,
    input logic                      rst,
    barrel_shift_right_pipe_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
        logic [SW-1:0]    sh;
        logic             ar;
        logic             st;
    } stg_t;

    logic [SW-1:0] vld;

    for (genvar k = 0; k < SW; k++) begin : g_stg
        localparam int S = 1 << k;
        localparam logic [WIDTH-1:0] LO = ~({WIDTH{1'b1}} << S);
        localparam logic [WIDTH-1:0] HI = ~({WIDTH{1'b1}} >> S);
        localparam logic [SW-1:0] UP = {SW{1'b1}} << k;

        stg_t src;
        stg_t nxt;
        stg_t q;
        logic adv;

        if (k == 0) begin : g_in
            assign src = '{
                v:  bus.in_valid,
                d:  bus.in_data,
                sh: bus.in_shamt,
                ar: bus.in_arith,
                st: 1'b0
            };
        end else begin : g_chain
            assign src = g_stg[k-1].q;
        end

        assign vld[k] = q.v;
        // A hole anywhere downstream (or a drained output) lets this stage move.
        assign adv = bus.out_ready | (|(~vld & UP));

        always_comb begin
            nxt = src;
            if (src.sh[k]) begin
                nxt.d  = (src.d >> S)
                       | ({WIDTH{src.ar & src.d[WIDTH-1]}} & HI);
                nxt.st = src.st | (|(src.d & LO));
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (adv) begin
                q <= nxt;
            end
        end
    end

    assign bus.in_ready   = g_stg[0].adv & ~rst;
    assign bus.out_valid  = g_stg[SW-1].q.v;
    assign bus.out_data   = g_stg[SW-1].q.d;
    assign bus.out_sticky = g_stg[SW-1].q.st;
endmodule

// File: tb/tb_barrel_shift_right_pipe.sv
// Scoreboard bench for barrel_shift_right_pipe: directed vectors,
// backpressure, reset flush and a random stream against a reference model.
module tb_barrel_shift_right_pipe;
    localparam int W  = 16;
    localparam int SW = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        int           acc;
        bit           lat;
    } item_t;

    logic clk;
    logic rst;
    barrel_shift_right_pipe_if #(.WIDTH(W)) bus ();

    barrel_shift_right_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk;
    int    n_fail;
    int    cyc;
    item_t sb[$];
    bit    dir_mode;
    bit    lat_mode;
    logic [W-1:0] exp_d;
    logic         exp_s;
    bit           stall_prev;
    logic [W-1:0] held_d;
    logic         held_s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model(input logic [W-1:0] d, input logic [SW-1:0] sh,
                         input logic ar, output logic [W-1:0] r, output logic s);
        logic [W-1:0] m;
        if (ar) r = W'($signed(d) >>> sh);
        else    r = d >> sh;
        m = (W'(1) << sh) - W'(1);
        s = |(d & m);
    endtask

    always @(negedge clk) begin
        item_t it;
        if (!rst && bus.in_valid && bus.in_ready) begin
            it.acc = cyc + 1;
            it.lat = lat_mode;
            if (dir_mode) begin
                it.d = exp_d;
                it.s = exp_s;
            end else begin
                model(bus.in_data, bus.in_shamt, bus.in_arith, it.d, it.s);
            end
            sb.push_back(it);
        end
    end

    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                if (stall_prev) begin
                    chk("hold_data", bus.out_data, held_d);
                    chk("hold_sticky", bus.out_sticky, held_s);
                end
                stall_prev = 1'b1;
                held_d = bus.out_data;
                held_s = bus.out_sticky;
            end else begin
                stall_prev = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    it = sb.pop_front();
                    chk("out_data", bus.out_data, it.d);
                    chk("out_sticky", bus.out_sticky, it.s);
                    if (it.lat) chk("latency", cyc + 1 - it.acc, SW);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] sh,
                        input logic ar, input logic [W-1:0] ed, input logic es);
        int n;
        exp_d = ed;
        exp_s = es;
        bus.in_data  = d;
        bus.in_shamt = sh;
        bus.in_arith = ar;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        dir_mode = 1'b1;
        lat_mode = 1'b0;
        stall_prev = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hAAAA;
        bus.in_shamt = 4'd3;
        bus.in_arith = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sticky", bus.out_sticky, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        lat_mode = 1'b1;
        send(16'h8001, 4'd1,  1'b0, 16'h4000, 1'b1); idle(6);
        send(16'h8000, 4'd15, 1'b1, 16'hFFFF, 1'b0); idle(6);
        send(16'h8000, 4'd15, 1'b0, 16'h0001, 1'b0); idle(6);
        send(16'hF0F0, 4'd4,  1'b0, 16'h0F0F, 1'b0); idle(6);
        send(16'hF0F0, 4'd4,  1'b1, 16'hFF0F, 1'b0); idle(6);
        send(16'h1234, 4'd0,  1'b0, 16'h1234, 1'b0); idle(6);
        send(16'h9234, 4'd0,  1'b1, 16'h9234, 1'b0); idle(6);
        lat_mode = 1'b0;

        bus.out_ready = 1'b0;
        fork
            begin
                send(16'h0001, 4'd0,  1'b0, 16'h0001, 1'b0);
                send(16'h0100, 4'd8,  1'b0, 16'h0001, 1'b0);
                send(16'h00FF, 4'd4,  1'b0, 16'h000F, 1'b1);
                send(16'hFF00, 4'd8,  1'b1, 16'hFFFF, 1'b0);
                @(negedge clk);
                chk("full_in_ready", bus.in_ready, 0);
                @(posedge clk);
                #1;
                send(16'h7FFF, 4'd15, 1'b1, 16'h0000, 1'b1);
                send(16'h8003, 4'd2,  1'b1, 16'hE000, 1'b1);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("no_gap_valid", bus.out_valid, 1);
                end
            end
        join
        idle(8);

        send(16'h1111, 4'd1, 1'b0, 16'h0888, 1'b1);
        send(16'h2222, 4'd2, 1'b0, 16'h0888, 1'b1);
        send(16'h4444, 4'd3, 1'b0, 16'h0888, 1'b1);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        idle(10);

        dir_mode = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = 16'($urandom);
            bus.in_shamt  = 4'($urandom_range(0, 15));
            bus.in_arith  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
